// File: rtl/uart_mem_loader_pkg.sv
// Shared constants and state encodings for the UART memory loader.
// Optional checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

   localparam logic [7:0] CMD_INSTR = 8'h49;
   localparam logic [7:0] CMD_DATA  = 8'h44;

   typedef enum logic [2:0] {
      IDLE,
      CNT_LO,
      CNT_HI,
      DATA,
      CHK,
      FINISH
   } frame_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_BITS,
      RX_STOP
   } rx_state_t;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_INSTR) || (b == CMD_DATA);
   endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// Memory write port and status bundle driven by the UART memory loader.
interface uart_mem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              wr_en;
   logic              wr_sel;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, busy, done, err
   );

   modport slave (
      input wr_en, wr_sel, wr_addr, wr_data, busy, done, err
   );
endinterface

// File: rtl/uart_mem_loader_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling down-counter, LSB-first shifter.
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | half-bit wait, then start bit re-checked (high = false start)
//   RX_BITS  | sampling 8 data bits one bit period apart
//   RX_STOP  | sampling the stop bit; high = byte valid, low = framing error
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err
);

   localparam int              CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        r_state;
   logic             r_rx_s1;
   logic             r_rx_s2;
   logic             r_rx_s3;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_byte_valid;
   logic             r_frame_err;
   logic             w_fall;

   // Edge, not level: a line held low after a framing error must not restart reception.
   assign w_fall = ~r_rx_s2 & r_rx_s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= RX_IDLE;
         r_rx_s1      <= 1'b1;
         r_rx_s2      <= 1'b1;
         r_rx_s3      <= 1'b1;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_rx_s1      <= i_rx;
         r_rx_s2      <= r_rx_s1;
         r_rx_s3      <= r_rx_s2;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               if (w_fall) begin
                  r_state <= RX_START;
                  r_cnt   <= HALF;
               end
            end
            RX_START: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_rx_s2) begin
                  r_state <= RX_IDLE;
               end else begin
                  r_state   <= RX_BITS;
                  r_cnt     <= FULL;
                  r_bit_idx <= '0;
               end
            end
            RX_BITS: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_shift   <= {r_rx_s2, r_shift[7:1]};
                  r_cnt     <= FULL;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) r_state <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_state <= RX_IDLE;
                  if (r_rx_s2) r_byte_valid <= 1'b1;
                  else         r_frame_err  <= 1'b1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   assign o_byte       = r_shift;
   assign o_byte_valid = r_byte_valid;
   assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_mem_loader.sv
// UART boot loader: framed byte stream -> little-endian 32-bit memory writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
//   state  | meaning
//   IDLE   | discarding bytes until an 'I' or 'D' command byte
//   CNT_LO | expecting word count low byte
//   CNT_HI | expecting word count high byte
//   DATA   | assembling words, write strobe after every 4th byte
//   CHK    | expecting checksum byte (checksum build only)
//   FINISH | one-cycle settle after frame end
module uart_mem_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx,
   input  logic               load_en,
   uart_mem_loader_if.master  bus
);

   logic [7:0]        w_byte;
   logic              w_byte_valid;
   logic              w_frame_err;
   logic [15:0]       w_count;

   frame_state_t      r_state;
   logic              r_wr_en;
   logic              r_wr_sel;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [31:0]       r_wr_data;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [7:0]        r_cnt_lo;
   logic [15:0]       r_words_left;
   logic [1:0]        r_idx;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
`endif

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk          (clk),
      .reset        (reset),
      .i_rx         (rx),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (w_frame_err)
   );

   assign w_count = {w_byte, r_cnt_lo};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_wr_en      <= 1'b0;
         r_wr_sel     <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_cnt_lo     <= '0;
         r_words_left <= '0;
         r_idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum       <= '0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         // Address advances the cycle after each strobe so the write sees a stable address.
         if (r_wr_en) r_wr_addr <= r_wr_addr + ADDR_W'(1);

         if (!load_en) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
         end else if (w_frame_err && (r_state != IDLE)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_idx   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_byte_valid && is_cmd(w_byte)) begin
                     r_state   <= CNT_LO;
                     r_wr_sel  <= (w_byte == CMD_DATA);
                     r_wr_addr <= '0;
                     r_err     <= 1'b0;
                     r_busy    <= 1'b1;
                     r_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
                     r_csum    <= '0;
`endif
                  end
               end
               CNT_LO: begin
                  if (w_byte_valid) begin
                     r_cnt_lo <= w_byte;
                     r_state  <= CNT_HI;
                  end
               end
               CNT_HI: begin
                  if (w_byte_valid) begin
                     r_words_left <= w_count;
                     if (w_count != 16'd0) begin
                        r_state <= DATA;
                     end else begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= CHK;
`else
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
`endif
                     end
                  end
               end
               DATA: begin
                  if (w_byte_valid) begin
                     r_wr_data[{r_idx, 3'b000} +: 8] <= w_byte;
                     r_idx <= r_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                     r_csum <= r_csum ^ w_byte;
`endif
                     if (r_idx == 2'd3) begin
                        r_wr_en      <= 1'b1;
                        r_words_left <= r_words_left - 16'd1;
                        if (r_words_left == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                           r_state <= CHK;
`else
                           r_state <= FINISH;
                           r_done  <= 1'b1;
                           r_busy  <= 1'b0;
`endif
                        end
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               CHK: begin
                  if (w_byte_valid) begin
                     r_state <= FINISH;
                     r_busy  <= 1'b0;
                     if (w_byte == r_csum) r_done <= 1'b1;
                     else                  r_err  <= 1'b1;
                  end
               end
`endif
               FINISH:  r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.wr_en   = r_wr_en;
   assign bus.wr_sel  = r_wr_sel;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.err     = r_err;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: frame-level model plus per-cycle compare of the write port and status.
module tb_uart_mem_loader;

   localparam int CPB = 4;
   localparam int AW  = 10;
`ifdef LOADER_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic rx = 1'b1;
   logic load_en = 1'b1;

   always #5 clk = ~clk;

   uart_mem_loader_if #(.ADDR_W(AW)) bus ();

   uart_mem_loader #(
      .CLKS_PER_BIT (CPB),
      .ADDR_W       (AW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .load_en (load_en),
      .bus     (bus)
   );

   typedef struct {
      int          at;
      bit          sel;
      int          addr;
      logic [31:0] data;
   } wr_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   bit          chk_en = 1'b0;

   wr_t         wq[$];
   int          dq[$];
   logic [7:0]  fb[$];
   bit          m_busy, m_err;
   bit          exp_busy, exp_err;
   int          pend_at = -1;
   bit          pend_busy, pend_err;
   logic [7:0]  xacc;

   logic [31:0] log_data[$];
   int          log_addr[$];
   bit          log_sel[$];
   int          n_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Frame-level model: collects the frame, derives writes/done/err from byte positions.
   task automatic model_byte(input logic [7:0] b, input bit ok, input int e);
      int n, len, k;
      logic [7:0] x;
      if (fb.size() == 0) begin
         if (ok && (b == 8'h49 || b == 8'h44)) begin
            fb.push_back(b);
            m_err  = 1'b0;
            m_busy = 1'b1;
         end
      end else if (!ok) begin
         fb.delete();
         m_err  = 1'b1;
         m_busy = 1'b0;
      end else begin
         fb.push_back(b);
         if (fb.size() >= 3) begin
            n   = int'({fb[2], fb[1]});
            len = 3 + 4 * n + CSUM;
            k   = fb.size() - 3;
            if (k > 0 && k <= 4 * n && (k % 4) == 0)
               wq.push_back('{e + 2, fb[0] == 8'h44, (k / 4 - 1) % (1 << AW),
                              {fb[k+2], fb[k+1], fb[k], fb[k-1]}});
            if (fb.size() == len) begin
               x = 8'h00;
               for (int i = 3; i < 3 + 4 * n; i++) x = x ^ fb[i];
               if (CSUM == 0 || x == b) dq.push_back(e + 2);
               else                     m_err = 1'b1;
               m_busy = 1'b0;
               fb.delete();
            end
         end
      end
      pend_at   = e + 2;
      pend_busy = m_busy;
      pend_err  = m_err;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (pend_at == cyc) begin
            exp_busy = pend_busy;
            exp_err  = pend_err;
            pend_at  = -1;
         end
         if (wq.size() > 0 && wq[0].at == cyc) begin
            chk("wr_en", bus.wr_en, 1);
            chk("wr_addr", bus.wr_addr, wq[0].addr);
            chk("wr_data", bus.wr_data, wq[0].data);
            chk("wr_sel", bus.wr_sel, wq[0].sel);
            void'(wq.pop_front());
         end else begin
            chk("wr_en quiet", bus.wr_en, 0);
         end
         if (dq.size() > 0 && dq[0] == cyc) begin
            chk("done", bus.done, 1);
            void'(dq.pop_front());
         end else begin
            chk("done quiet", bus.done, 0);
         end
         chk("busy", bus.busy, exp_busy);
         chk("err", bus.err, exp_err);
      end
      if (bus.wr_en) begin
         log_data.push_back(bus.wr_data);
         log_addr.push_back(int'(bus.wr_addr));
         log_sel.push_back(bus.wr_sel);
      end
      if (bus.done) n_done++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_byte(input logic [7:0] b, input bit ok);
      logic [9:0] f;
      f = {ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      model_byte(b, ok, cyc);
   endtask

   task automatic tx_hdr(input logic [7:0] cmd, input int n);
      logic [15:0] c;
      c = 16'(n);
      xacc = 8'h00;
      tx_byte(cmd, 1'b1);
      tx_byte(c[7:0], 1'b1);
      tx_byte(c[15:8], 1'b1);
   endtask

   task automatic tx_data(input logic [7:0] b);
      xacc = xacc ^ b;
      tx_byte(b, 1'b1);
   endtask

   task automatic tx_csum();
      if (CSUM != 0) tx_byte(xacc, 1'b1);
   endtask

   task automatic model_clear();
      fb.delete();
      wq.delete();
      dq.delete();
      m_busy   = 1'b0;
      m_err    = 1'b0;
      exp_busy = 1'b0;
      exp_err  = 1'b0;
      pend_at  = -1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " wr_en"},   bus.wr_en,   0);
      chk({tag, " wr_sel"},  bus.wr_sel,  0);
      chk({tag, " wr_addr"}, bus.wr_addr, 0);
      chk({tag, " wr_data"}, bus.wr_data, 0);
      chk({tag, " busy"},    bus.busy,    0);
      chk({tag, " done"},    bus.done,    0);
      chk({tag, " err"},     bus.err,     0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nl, nd;
      logic [7:0] t1 [8];
      t1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      model_clear();
      repeat (3) @(negedge clk);
      #1 chk_reset_vals("por");
      @(negedge clk);
      reset  = 1'b1;
      chk_en = 1'b1;
      idle(5);

      // Two-word instruction frame
      tx_hdr(8'h49, 2);
      foreach (t1[i]) tx_data(t1[i]);
      tx_csum();
      idle(5);
      chk("t1 writes", log_data.size(), 2);
      if (log_data.size() == 2) begin
         chk("t1 data0", log_data[0], 32'h12345678);
         chk("t1 addr0", log_addr[0], 0);
         chk("t1 sel0",  log_sel[0],  0);
         chk("t1 data1", log_data[1], 32'hDEADBEEF);
         chk("t1 addr1", log_addr[1], 1);
      end
      chk("t1 addr after", bus.wr_addr, 2);
      chk("t1 busy", bus.busy, 0);
      chk("t1 dones", n_done, 1);

      // Empty data frame
      tx_hdr(8'h44, 0);
      tx_csum();
      idle(5);
      chk("t2 sel", bus.wr_sel, 1);
      chk("t2 dones", n_done, 2);
      chk("t2 writes", log_data.size(), 2);

      // Stray byte before a valid command
      tx_byte(8'h41, 1'b1);
      tx_hdr(8'h44, 1);
      tx_data(8'h01); tx_data(8'h02); tx_data(8'h03); tx_data(8'h04);
      tx_csum();
      idle(5);
      chk("t3 writes", log_data.size(), 3);
      chk("t3 data", log_data[log_data.size()-1], 32'h04030201);
      chk("t3 sel",  log_sel[log_sel.size()-1], 1);

      // Framing error mid-word, then recovery
      tx_hdr(8'h49, 1);
      tx_data(8'h11);
      tx_byte(8'h22, 1'b0);
      idle(10);
      chk("t4 err", bus.err, 1);
      chk("t4 busy", bus.busy, 0);
      chk("t4 writes", log_data.size(), 3);
      tx_hdr(8'h49, 1);
      tx_data(8'h01); tx_data(8'h02); tx_data(8'h03); tx_data(8'h04);
      tx_csum();
      idle(5);
      chk("t4 err cleared", bus.err, 0);
      chk("t4 data", log_data[log_data.size()-1], 32'h04030201);
      chk("t4 sel",  log_sel[log_sel.size()-1], 0);

      // One-cycle glitch between frame bytes must not be taken as a byte
      tx_hdr(8'h44, 2);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      idle(10);
      for (int i = 1; i <= 8; i++) tx_data(8'(i * 16));
      tx_csum();
      idle(5);
      chk("t5 data0", log_data[log_data.size()-2], 32'h40302010);
      chk("t5 data1", log_data[log_data.size()-1], 32'h80706050);
      chk("t5 addr1", log_addr[log_addr.size()-1], 1);

      // load_en dropped mid-word
      nl = log_data.size();
      nd = n_done;
      tx_hdr(8'h49, 1);
      tx_data(8'hAA);
      tx_data(8'hBB);
      idle(5);
      load_en = 1'b0;
      fb.delete();
      m_busy    = 1'b0;
      pend_at   = cyc + 1;
      pend_busy = 1'b0;
      pend_err  = m_err;
      idle(3);
      load_en = 1'b1;
      idle(5);
      tx_byte(8'hCC, 1'b1);
      tx_byte(8'hDD, 1'b1);
      idle(5);
      chk("t6 busy", bus.busy, 0);
      chk("t6 writes", log_data.size(), nl);
      chk("t6 dones", n_done, nd);

      // Reset mid-frame
      tx_hdr(8'h44, 1);
      tx_data(8'hAA);
      idle(5);
      chk_en = 1'b0;
      reset  = 1'b0;
      #1 chk_reset_vals("midrst");
      idle(3);
      model_clear();
      reset  = 1'b1;
      chk_en = 1'b1;
      tx_byte(8'hCC, 1'b1);
      tx_byte(8'hDD, 1'b1);
      tx_byte(8'hEE, 1'b1);
      idle(5);
      chk("t7 writes", log_data.size(), nl);
      chk("t7 busy", bus.busy, 0);

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum: write stands, err set, no done
      nd = n_done;
      tx_hdr(8'h49, 1);
      tx_data(8'h01); tx_data(8'h02); tx_data(8'h03); tx_data(8'h04);
      tx_byte(8'h05, 1'b1);
      idle(5);
      chk("t8 err", bus.err, 1);
      chk("t8 dones", n_done, nd);
      chk("t8 data", log_data[log_data.size()-1], 32'h04030201);
`endif

      idle(5);
      chk("writes drained", wq.size(), 0);
      chk("dones drained", dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

UART boot loader for the pipelined MIPS CPU: receives a framed byte stream on the serial line, assembles little-endian 32-bit words and writes them into instruction or data memory through the bus write port. It is the hardware counterpart of the bench-side memory preload: a host fills memory over UART while the CPU is held idle. It sits beside the bus, ahead of the memories' write multiplexer.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4
- ADDR_W, 10, word-address width of the target memories
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  asynchronous, active-low; 0 resets all state
- rx  in  1  UART line, idle high, 8N1, LSB first
- load_en  in  1  1 = loader active; 0 = aborts any frame, returns to IDLE
- wr_en  out  1  one-cycle memory write strobe
- wr_sel  out  1  0 = instruction memory, 1 = data memory
- wr_addr  out  ADDR_W  word address of the write
- wr_data  out  32  word to write
- busy  out  1  1 from command-byte acceptance until frame end
- done  out  1  one-cycle pulse on successful frame completion
- err  out  1  sticky error; cleared when the next valid command byte is accepted

## Operation
- Frame: CMD byte (0x49 'I' -> wr_sel=0, 0x44 'D' -> wr_sel=1), COUNT_LO, COUNT_HI (N words, 16 bit), then 4N data bytes, each word LSB first; writes start at address 0.
- Frame FSM states: IDLE, CNT_LO, CNT_HI, DATA, (CHK), FINISH.
- IDLE: any byte other than 0x49/0x44 is discarded, err unchanged.
- DATA: byte index 0..3 fills wr_data[7:0]..[31:24]; after byte 3, wr_en pulses, then wr_addr increments (mod 2^ADDR_W, wraps silently).
- N=0: no writes; DATA skipped.
- Framing error (stop bit sampled 0) in any non-IDLE state: err=1, frame aborted to IDLE, no write for the partial word.
- load_en=0 at any time: immediate return to IDLE, busy=0, partial word discarded, err unchanged.
- Byte receiver: rx through 2-flop synchronizer; falling edge starts bit timer; start bit re-checked at CLKS_PER_BIT/2 (high -> false start, ignored); data bits sampled every CLKS_PER_BIT from there; then stop bit.

## Timing
- Reset values: wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
- byte_valid (internal) pulses the cycle after the stop-bit sample.
- wr_en asserts the cycle after byte_valid of byte 3; wr_addr/wr_data/wr_sel stable during that cycle; wr_addr updates the cycle after.
- done pulses the cycle after the last frame byte's byte_valid (last data byte, COUNT_HI if N=0, or checksum); busy falls in the same cycle.
- Synchronizer adds 2 cycles from rx edge to start detection.
- Consecutive words spaced ≥ 40*CLKS_PER_BIT cycles; no backpressure exists, memory accepts wr_en every cycle.

## Configuration
- LOADER_CHECKSUM_EN defined: one extra byte after the data (state CHK) equal to XOR of all 4N data bytes; mismatch -> err=1, done not pulsed (writes already made remain). Without it: no checksum byte, FINISH follows the last data byte.

## Structure
- Package loader_pkg: CMD_INSTR=8'h49, CMD_DATA=8'h44, frame-FSM state encoding, receiver state encoding (RX_IDLE, RX_START, RX_BITS, RX_STOP).
- Sub-module uart_rx_byte: synchronizer, bit timer, shifter; outputs byte, byte_valid, frame_err. Top holds frame FSM, word assembler, address counter, checksum.

## Test plan
- CLKS_PER_BIT=4: send 49 02 00 78 56 34 12 EF BE AD DE -> wr_en at addr 0 data 0x12345678 sel 0, addr 1 data 0xDEADBEEF, then done pulse, busy=0.
- Send 44 00 00 -> no wr_en, done one cycle after COUNT_HI byte, wr_sel=1.
- Send 41 then 44 01 00 01 02 03 04 -> 0x41 ignored; one write addr 0 data 0x04030201 sel 1.
- Data byte with stop bit 0 mid-word -> err=1, busy=0, no write; following valid 49 01 00 ... clears err and writes.
- Glitch rx low for 1 cycle, drop load_en mid-word, assert reset mid-frame -> no byte accepted, IDLE with no write, all outputs reset values respectively.
- With LOADER_CHECKSUM_EN: 49 01 00 01 02 03 04 04 -> write, done; checksum 05 instead -> err=1, no done.
